// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss fill handler.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned DATA_W      = 16;
    // Byte-offset bits within a block (16-bit words, so two bytes per word).
    localparam int unsigned OFFSET_MASK = 2 * BLOCK_WORDS - 1;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/fill_counter.sv
// Resettable up-counter with enable, synchronous clear and terminal-count flag.
module fill_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Count register; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    // Terminal count reached.
    always_comb begin
        tc = (count == WIDTH'(LIMIT));
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: arbitrates I/D misses (D first), streams one block
// from pipelined main memory into the selected cache, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_miss,
    input  logic [ADDR_W-1:0]             i_miss_addr,
    input  logic                          d_miss,
    input  logic [ADDR_W-1:0]             d_miss_addr,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_data_valid,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          fill_sel,
    output logic                          fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          tag_we,
    output logic                          i_done,
    output logic                          d_done,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(OFFSET_MASK);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  base;
    logic               sel;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   recv_cnt;
    logic               issue_tc;
    logic               recv_tc;
    logic               filling;
    logic               issue_en;
    logic               recv_en;
    logic               last_word;

    // Issue/receive qualifiers derived from the registered state and counters.
    always_comb begin
        filling   = (state == FILL);
        issue_en  = filling && !issue_tc;
        recv_en   = filling && mem_data_valid && !recv_tc;
        last_word = recv_en && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));
    end

    // Read-issue counter: one read per cycle until the block is requested.
    fill_counter #(
        .WIDTH (CNT_W),
        .LIMIT (BLOCK_WORDS)
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (last_word),
        .en    (issue_en),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    // Receive counter: tracks which word of the block is being written.
    fill_counter #(
        .WIDTH (CNT_W),
        .LIMIT (BLOCK_WORDS)
    ) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (last_word),
        .en    (recv_en),
        .count (recv_cnt),
        .tc    (recv_tc)
    );

    // Next-state: leave IDLE on any miss, return once the last word lands.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_miss || i_miss) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, block base and target select; D wins arbitration in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
            sel   <= FILL_SEL_I;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (d_miss) begin
                    base <= d_miss_addr & BLOCK_MASK;
                    sel  <= FILL_SEL_D;
                end else if (i_miss) begin
                    base <= i_miss_addr & BLOCK_MASK;
                    sel  <= FILL_SEL_I;
                end
            end
        end
    end

    // Output decode; data path outputs are zero when not writing.
    always_comb begin
        mem_rd_en = issue_en;
        mem_addr  = '0;
        if (issue_en) begin
            mem_addr = base + (ADDR_W'(issue_cnt) << 1);
        end
        fill_we   = recv_en;
        fill_word = '0;
        fill_data = '0;
        if (recv_en) begin
            fill_word = IDX_W'(recv_cnt);
            fill_data = mem_data;
        end
        tag_we   = last_word;
        d_done   = last_word && (sel == FILL_SEL_D);
        i_done   = last_word && (sel == FILL_SEL_I);
        fill_sel = sel;
        busy     = filling || i_miss || d_miss;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a pipelined memory model and a
// scoreboard of expected fill writes.
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        fill_sel;
    logic        fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        tag_we;
    logic        i_done;
    logic        d_done;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    int   lat   = 4;
    logic stray;

    typedef struct packed {
        logic        sel;
        logic [2:0]  word;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .fill_sel       (fill_sel),
        .fill_we        (fill_we),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .tag_we         (tag_we),
        .i_done         (i_done),
        .d_done         (d_done),
        .busy           (busy)
    );

    // Memory contents as a function of address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Pipelined memory: a read issued in cycle n returns in cycle n+lat.
    logic        pv [8];
    logic [15:0] pa [8];
    logic [2:0]  tap;
    assign tap = 3'(lat - 1);
    always @(posedge clk) begin
        pv[0] <= mem_rd_en;
        pa[0] <= mem_addr;
        for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data_valid = pv[tap] | stray;
    assign mem_data       = pv[tap] ? mem_fn(pa[tap]) : 16'hBEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks for cycle c after the request was sampled.
    task automatic check_cycle(input int c, input logic is_d, input logic [15:0] base);
        logic exp_rd;
        logic exp_we;
        logic last;
        sb_t  e;
        exp_rd = (c >= 1) && (c <= 8);
        exp_we = (c >= 1 + lat) && (c <= 8 + lat);
        last   = (c == 8 + lat);
        check($sformatf("rd_en c%0d", c), 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) begin
            check($sformatf("mem_addr c%0d", c), 32'(mem_addr), 32'(base + 16'(2 * (c - 1))));
        end
        check($sformatf("fill_we c%0d", c), 32'(fill_we), 32'(exp_we));
        if (fill_we) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check($sformatf("fill_word c%0d", c), 32'(fill_word), 32'(e.word));
                check($sformatf("fill_data c%0d", c), 32'(fill_data), 32'(e.data));
                check($sformatf("fill_sel_we c%0d", c), 32'(fill_sel), 32'(e.sel));
            end
        end
        check($sformatf("tag_we c%0d", c), 32'(tag_we), 32'(last));
        check($sformatf("d_done c%0d", c), 32'(d_done), 32'(last && is_d));
        check($sformatf("i_done c%0d", c), 32'(i_done), 32'(last && !is_d));
        check($sformatf("fill_sel c%0d", c), 32'(fill_sel), 32'(is_d));
        check($sformatf("busy c%0d", c), 32'(busy), 32'd1);
    endtask

    // Raise a miss in the current cycle and follow the fill to completion.
    task automatic do_fill(input logic is_d, input logic [15:0] addr, input int drop_at);
        logic [15:0] base;
        base = addr & ~16'(OFFSET_MASK);
        if (is_d) begin
            d_miss_addr = addr;
            d_miss      = 1'b1;
        end else begin
            i_miss_addr = addr;
            i_miss      = 1'b1;
        end
        for (int w = 0; w < 8; w++) begin
            sb_q.push_back('{sel: is_d, word: 3'(w), data: mem_fn(base + 16'(2 * w))});
        end
        #1;
        check("busy_miss_cycle", 32'(busy), 32'd1);
        check("rd_en_miss_cycle", 32'(mem_rd_en), 32'd0);
        for (int c = 1; c <= 8 + lat; c++) begin
            tick();
            check_cycle(c, is_d, base);
            if (c == drop_at || c == 8 + lat) begin
                if (is_d) d_miss = 1'b0;
                else      i_miss = 1'b0;
            end
        end
        tick();
        check("idle_rd_en", 32'(mem_rd_en), 32'd0);
        check("idle_tag_we", 32'(tag_we), 32'd0);
        check("idle_done", 32'({i_done, d_done}), 32'd0);
        check("idle_busy", 32'(busy), 32'(i_miss | d_miss));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        stray = 1'b1;
        #1;
        check("extra_valid_we", 32'(fill_we), 32'd0);
        stray = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_fill_we"}, 32'(fill_we), 32'd0);
        check({tag, "_fill_word"}, 32'(fill_word), 32'd0);
        check({tag, "_fill_data"}, 32'(fill_data), 32'd0);
        check({tag, "_tag_we"}, 32'(tag_we), 32'd0);
        check({tag, "_dones"}, 32'({i_done, d_done}), 32'd0);
        check({tag, "_fill_sel"}, 32'(fill_sel), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] base;
        rst_n       = 1'b0;
        i_miss      = 1'b0;
        d_miss      = 1'b0;
        i_miss_addr = '0;
        d_miss_addr = '0;
        stray       = 1'b0;
        repeat (10) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Stray valid while idle.
        stray = 1'b1;
        #1;
        check("idle_stray_we", 32'(fill_we), 32'd0);
        check("idle_stray_tag", 32'(tag_we), 32'd0);
        check("idle_busy0", 32'(busy), 32'd0);
        stray = 1'b0;
        tick();

        // Single D miss.
        do_fill(1'b1, 16'h1236, 0);
        tick();

        // Simultaneous I and D: D first, then I after one idle cycle.
        i_miss_addr = 16'h0040;
        i_miss      = 1'b1;
        do_fill(1'b1, 16'h2008, 0);
        do_fill(1'b0, 16'h0040, 0);
        tick();

        // Top of memory.
        do_fill(1'b1, 16'hFFFE, 0);
        tick();

        // Reset after three fill writes.
        base        = 16'h3450;
        d_miss_addr = 16'h3456;
        d_miss      = 1'b1;
        for (int w = 0; w < 8; w++) begin
            sb_q.push_back('{sel: 1'b1, word: 3'(w), data: mem_fn(base + 16'(2 * w))});
        end
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_cycle(c, 1'b1, base);
        end
        tick();
        rst_n  = 1'b0;
        d_miss = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_sb_left", 32'(sb_q.size()), 32'd5);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        for (int c = 9; c <= 12; c++) begin
            check($sformatf("post_rst_we c%0d", c), 32'(fill_we), 32'd0);
            check($sformatf("post_rst_tag c%0d", c), 32'(tag_we), 32'd0);
            check($sformatf("post_rst_done c%0d", c), 32'(d_done), 32'd0);
            tick();
        end
        check("post_rst_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        do_fill(1'b1, 16'h3456, 0);
        tick();

        // D miss dropped in cycle 3 still completes.
        do_fill(1'b1, 16'h0A0A, 3);
        tick();

        // Single-cycle memory latency.
        lat = 1;
        tick();
        do_fill(1'b1, 16'h4444, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
